neuron_mac_stream: RTL and testbench
====================================

// Module: neuron_mac_stream
// PURPOSE
//  Parametrised successor to the per-neuron MAC used in the FNN accelerator layers.
//  - Stores its own weights and bias, both loaded over the shared config bus.
//  - Streams one input vector of NUM_WEIGHT samples and runs a saturating fixed-point MAC.
//  - Adds the bias, then applies a runtime-selected activation.
//  - Returns one result over a valid/ready handshake, with input back-pressure.
// PARAMETERS
//  LAYER_NO    1    layer index matched against cfg_layer
//  NEURON_NO   0    neuron index matched against cfg_neuron
//  NUM_WEIGHT  784  weights (and input samples) per vector; >=2
//  DATA_W      16   signed width of input, weight, bias, output
//  FRAC_W      8    fractional bits of the Q format (input/weight/bias/output)
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous active-high reset
//  cfg_layer   in   32       layer select for weight/bias load
//  cfg_neuron  in   32       neuron select for weight/bias load
//  w_valid     in   1        weight write strobe
//  w_data      in   32       weight; [DATA_W-1:0] used
//  b_valid     in   1        bias write strobe
//  b_data      in   32       bias; [DATA_W-1:0] used
//  w_load_done out  1        NUM_WEIGHT weights written since reset
//  act_mode    in   2        0 linear, 1 ReLU, 2 leaky ReLU (x>>>3), 3 = linear
//  in_valid    in   1        input sample valid
//  in_data     in   DATA_W   signed input sample
//  in_ready    out  1        block accepts a sample
//  out_valid   out  1        result valid
//  out_ready   in   1        consumer accepts the result
//  out_data    out  DATA_W   signed activated result
//  busy        out  1        state != IDLE
// BEHAVIOUR
//  Reset:
//  - State -> IDLE; accumulator, sample count and w_ptr cleared.
//  - out_valid=0, out_data=0, w_load_done=0, busy=0; in_ready=1 from the first post-reset cycle.
//  - Weight RAM and bias_reg keep their contents; they are configuration, not state.
//  Loading:
//  - Weight write when w_valid & cfg_layer==LAYER_NO & cfg_neuron==NEURON_NO & state==IDLE.
//    mem[w_ptr] <= w_data[DATA_W-1:0]; w_ptr increments and wraps NUM_WEIGHT-1 -> 0.
//    w_load_done sets when the write to NUM_WEIGHT-1 completes and stays set until rst.
//  - Bias write on the same match: bias_reg <= b_data[DATA_W-1:0].
//  - Weight and bias writes in the same cycle are both performed.
//  - Load strobes outside IDLE, or with a cfg mismatch, are ignored.
//  FSM states: IDLE, ACC, DRAIN, BIAS, ACT, OUT.
//  - IDLE: first accepted sample -> ACC.
//  - ACC: the NUM_WEIGHT-th accepted sample -> DRAIN.
//  - DRAIN: MAC pipeline empty -> BIAS.
//  - BIAS -> ACT -> OUT, one cycle each.
//  - OUT: out_valid & out_ready -> IDLE; accumulator and count clear on that edge.
//  Input handshake:
//  - in_ready=1 only in IDLE and ACC.
//  - A sample is accepted on in_valid & in_ready; the nth accepted sample multiplies mem[n].
//  - Gaps in in_valid are allowed and do not corrupt the sum.
//  Arithmetic:
//  - Product is signed DATA_W x DATA_W -> 2*DATA_W bits, with 2*FRAC_W fractional bits.
//  - Accumulator is 2*DATA_W signed. Each add saturates to max/min when both operands
//    share a sign and the sum's sign differs.
//  - Bias is sign-extended, shifted left by FRAC_W, then added with the same saturation.
//  - ACT: y = acc>>>FRAC_W, saturated to signed DATA_W range.
//    Mode 1: y<0 -> 0. Mode 2: y<0 -> y>>>3.
//  Output and latency:
//  - out_valid rises exactly 5 cycles after the edge accepting the last sample.
//  - out_valid/out_data hold stable until out_ready; a new vector may start on the next cycle.
//  - act_mode is sampled in ACT; changes at other times do not affect the current result.
//  - rst mid-vector aborts the vector; no out_valid is produced for it.
// TESTING (NUM_WEIGHT=4, DATA_W=16, FRAC_W=8 unless stated)
//  1 Weights 0x0100 x4, bias 0x0080, inputs 0x0100,0x0200,0x0300,0x0400, mode 0
//    -> out_data 0x0A80; out_valid exactly 5 cycles after last accept.
//  2 Same weights, bias 0, inputs 0xFF00 x4: mode 1 -> 0x0000; mode 2 -> 0xFF80.
//  3 Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF, mode 0 -> 0x7FFF (saturated).
//    Negated inputs -> 0x8000.
//  4 Hold out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0.
//    Repeat vector -> identical result (accumulator cleared).
//  5 w_valid with cfg_neuron!=NEURON_NO, or during ACC -> RAM unchanged, w_load_done unchanged.
//    in_valid toggling every other cycle -> result as test 1.
//  6 rst after 2 accepted samples -> out_valid=0 and in_ready=1 next cycle.
//    A full new vector -> correct result using retained weights and bias.

Source files
------------

// File: rtl/neuron_mac_stream_if.sv
// Bundle of the configuration bus, the input sample stream and the result stream of one
// neuron_mac_stream instance.
//   master : the side that loads configuration, pushes samples and accepts results
//   slave  : the neuron itself
// Signals
//   cfg_layer/cfg_neuron  layer/neuron select for weight and bias loads
//   w_valid/w_data        weight write strobe and data ([DATA_W-1:0] used)
//   b_valid/b_data        bias write strobe and data ([DATA_W-1:0] used)
//   w_load_done           a full set of weights has been written since reset
//   act_mode              0/3 linear, 1 ReLU, 2 leaky ReLU (x>>>3)
//   in_valid/in_ready/in_data     input sample handshake
//   out_valid/out_ready/out_data  result handshake
//   busy                  neuron is not idle
interface neuron_mac_stream_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [31:0]              cfg_layer;
    logic [31:0]              cfg_neuron;
    logic                     w_valid;
    logic [31:0]              w_data;
    logic                     b_valid;
    logic [31:0]              b_data;
    logic                     w_load_done;
    logic [1:0]               act_mode;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;

    modport master (
        output cfg_layer, cfg_neuron, w_valid, w_data, b_valid, b_data, act_mode,
        output in_valid, in_data, out_ready,
        input  w_load_done, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  cfg_layer, cfg_neuron, w_valid, w_data, b_valid, b_data, act_mode,
        input  in_valid, in_data, out_ready,
        output w_load_done, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/neuron_mac_stream.sv
// Single neuron: holds its own weights and bias (loaded over the shared config bus), streams
// one vector of NUM_WEIGHT signed fixed-point samples through a saturating MAC, adds the bias,
// applies a runtime-selected activation and returns one result over valid/ready.
// Ports
//   clk  clock
//   rst  synchronous active-high reset
//   bus  neuron_mac_stream_if slave: config load, input stream, result stream, status
// The interface instance must be built with the same DATA_W as this module.
module neuron_mac_stream #(
    parameter int unsigned LAYER_NO   = 1,
    parameter int unsigned NEURON_NO  = 0,
    parameter int unsigned NUM_WEIGHT = 784,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAC_W     = 8
) (
    input logic               clk,
    input logic               rst,
    neuron_mac_stream_if.slave bus
);
    localparam int unsigned AW = 2 * DATA_W;
    localparam int unsigned CW = $clog2(NUM_WEIGHT);

    localparam logic signed [AW-1:0]     ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0]     ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0]     Y_MAX   = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0]     Y_MIN   = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAcc, StDrain, StBias, StAct, StOut} state_e;

    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            w_ptr_q;
    logic                     w_load_done_q;
    logic signed [AW-1:0]     acc_q;
    logic                     s1_v_q;
    logic                     p_v_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] w_q;
    logic signed [AW-1:0]     prod_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;

    // Configuration storage: deliberately not reset.
    logic signed [DATA_W-1:0] mem [NUM_WEIGHT];
    logic signed [DATA_W-1:0] bias_q;

    logic                     in_ready;
    logic                     accept;
    logic                     last_sample;
    logic                     cfg_match;
    logic                     w_we;
    logic                     b_we;
    logic signed [AW-1:0]     x_ext;
    logic signed [AW-1:0]     w_ext;
    logic signed [AW-1:0]     bias_sh;
    logic signed [AW-1:0]     y_full;
    logic signed [DATA_W-1:0] y_sat;
    logic signed [DATA_W-1:0] act_y;
    logic                     unused_hi;

    assign unused_hi = ^{bus.w_data[31:DATA_W], bus.b_data[31:DATA_W]};

    assign in_ready    = (state_q == StIdle) || (state_q == StAcc);
    assign accept      = bus.in_valid && in_ready;
    assign last_sample = (cnt_q == CW'(NUM_WEIGHT - 1));
    assign cfg_match   = (bus.cfg_layer == LAYER_NO) && (bus.cfg_neuron == NEURON_NO);
    assign w_we        = bus.w_valid && cfg_match && (state_q == StIdle);
    assign b_we        = bus.b_valid && cfg_match && (state_q == StIdle);

    assign x_ext   = {{DATA_W{x_q[DATA_W-1]}}, x_q};
    assign w_ext   = {{DATA_W{w_q[DATA_W-1]}}, w_q};
    assign bias_sh = {{DATA_W{bias_q[DATA_W-1]}}, bias_q} <<< FRAC_W;

    // Add that clamps on signed overflow instead of wrapping.
    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                      input logic signed [AW-1:0] b);
        logic signed [AW-1:0] s;
        s = a + b;
        if ((a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1])) begin
            s = a[AW-1] ? ACC_MIN : ACC_MAX;
        end
        return s;
    endfunction

    // Rescale to the output Q format, clamp, then apply the activation.
    always_comb begin
        y_full = acc_q >>> FRAC_W;
        if (y_full > Y_MAX) begin
            y_sat = D_MAX;
        end else if (y_full < Y_MIN) begin
            y_sat = D_MIN;
        end else begin
            y_sat = y_full[DATA_W-1:0];
        end
        act_y = y_sat;
        if (y_sat[DATA_W-1]) begin
            case (bus.act_mode)
                2'd1:    act_y = '0;
                2'd2:    act_y = y_sat >>> 3;
                default: act_y = y_sat;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_ptr_q] <= bus.w_data[DATA_W-1:0];
        end
        if (b_we) begin
            bias_q <= bus.b_data[DATA_W-1:0];
        end
    end

    // MAC datapath: stage 1 captures sample and weight, stage 2 forms the product.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q <= bus.in_data;
            w_q <= mem[cnt_q];
        end
        if (s1_v_q) begin
            prod_q <= x_ext * w_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            w_ptr_q       <= '0;
            w_load_done_q <= 1'b0;
            acc_q         <= '0;
            s1_v_q        <= 1'b0;
            p_v_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            s1_v_q <= accept;
            p_v_q  <= s1_v_q;

            if (w_we) begin
                w_ptr_q <= (w_ptr_q == CW'(NUM_WEIGHT - 1)) ? '0 : w_ptr_q + 1'b1;
                if (w_ptr_q == CW'(NUM_WEIGHT - 1)) begin
                    w_load_done_q <= 1'b1;
                end
            end

            if (accept) begin
                cnt_q <= last_sample ? '0 : cnt_q + 1'b1;
            end

            if (p_v_q) begin
                acc_q <= sat_add(acc_q, prod_q);
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    if (accept && last_sample) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Wait until the last product has been folded into the accumulator.
                    if (!s1_v_q && !p_v_q) begin
                        state_q <= StBias;
                    end
                end
                StBias: begin
                    acc_q   <= sat_add(acc_q, bias_sh);
                    state_q <= StAct;
                end
                StAct: begin
                    out_data_q  <= act_y;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.w_load_done = w_load_done_q;
    assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Directed bench for neuron_mac_stream with NUM_WEIGHT=4, DATA_W=16, FRAC_W=8.
module tb_neuron_mac_stream;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    neuron_mac_stream_if #(.DATA_W(16)) bus ();

    neuron_mac_stream #(
        .LAYER_NO  (1),
        .NEURON_NO (0),
        .NUM_WEIGHT(4),
        .DATA_W    (16),
        .FRAC_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    // Write the same weight to all four slots and the bias, with matching cfg.
    task automatic load_params(input logic [15:0] w, input logic [15:0] b);
        @(negedge clk);
        bus.cfg_layer  = 32'd1;
        bus.cfg_neuron = 32'd0;
        bus.w_valid    = 1'b1;
        bus.w_data     = {16'h0, w};
        bus.b_valid    = 1'b1;
        bus.b_data     = {16'h0, b};
        repeat (4) @(negedge clk);
        bus.w_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    // Push four samples; optional idle gap after each but the last, optional matched load
    // strobes during those gaps. Returns at the negedge after the last accept.
    task automatic send_vec(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] x2, input logic [15:0] x3,
                            input bit gaps, input bit strobe, output bit ok);
        logic [15:0] xs [4];
        int          n;
        xs = '{x0, x1, x2, x3};
        ok = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = xs[i];
            n = 0;
            while (!bus.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n == 20) ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (gaps && i < 3) begin
                if (strobe) begin
                    bus.cfg_layer  = 32'd1;
                    bus.cfg_neuron = 32'd0;
                    bus.w_valid    = 1'b1;
                    bus.w_data     = 32'h0000_7FFF;
                    bus.b_valid    = 1'b1;
                    bus.b_data     = 32'h0000_7FFF;
                end
                @(negedge clk);
                bus.w_valid = 1'b0;
                bus.b_valid = 1'b0;
            end
        end
    endtask

    // Count rising edges until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        tests++;
        if (bus.out_data !== 16'h0000) begin
            fails++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data);
        end
        tests++;
        if (bus.w_load_done !== 1'b0) begin
            fails++; $display("FAIL reset_w_load_done: got %b want 0", bus.w_load_done);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        load_params(16'h0100, 16'h0080);
        tests++;
        if (bus.w_load_done !== 1'b1) begin
            fails++; $display("FAIL basic_load_done: got %b want 1", bus.w_load_done);
        end
        bus.act_mode = 2'd0;
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, 1'b0, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL basic_accept: got timeout want accepted");
        end
        wait_out(lat);
        tests++;
        if (lat != 5) begin
            fails++; $display("FAIL basic_latency: got %0d want 5", lat);
        end
        tests++;
        if (bus.out_data !== 16'h0A80) begin
            fails++; $display("FAIL basic_data: got %h want 0a80", bus.out_data);
        end
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++; $display("FAIL basic_busy: got %b want 1", bus.busy);
        end
        consume();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_valid_clear: got %b want 0", bus.out_valid);
        end
        tests++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: got in_ready %b busy %b want 1 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_activation();
        bit ok;
        int lat;
        load_params(16'h0100, 16'h0000);
        bus.act_mode = 2'd1;
        send_vec(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000) begin
            fails++;
            $display("FAIL act_relu: got v%b %h want v1 0000", bus.out_valid, bus.out_data);
        end
        consume();
        bus.act_mode = 2'd2;
        send_vec(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFF80) begin
            fails++;
            $display("FAIL act_leaky: got v%b %h want v1 ff80", bus.out_valid, bus.out_data);
        end
        // Mode change while the result is held must not alter it.
        @(negedge clk);
        bus.act_mode = 2'd1;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.out_data !== 16'hFF80) begin
            fails++; $display("FAIL act_mode_hold: got %h want ff80", bus.out_data);
        end
        consume();
        bus.act_mode = 2'd3;
        send_vec(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFC00) begin
            fails++;
            $display("FAIL act_mode3: got v%b %h want v1 fc00", bus.out_valid, bus.out_data);
        end
        consume();
    endtask

    task automatic test_saturation();
        bit ok;
        int lat;
        load_params(16'h7FFF, 16'h7FFF);
        bus.act_mode = 2'd0;
        send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7FFF) begin
            fails++;
            $display("FAIL sat_pos: got v%b %h want v1 7fff", bus.out_valid, bus.out_data);
        end
        consume();
        send_vec(16'h8001, 16'h8001, 16'h8001, 16'h8001, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000) begin
            fails++;
            $display("FAIL sat_neg: got v%b %h want v1 8000", bus.out_valid, bus.out_data);
        end
        consume();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        int bad;
        load_params(16'h0100, 16'h0080);
        bus.act_mode = 2'd0;
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (lat != 5) begin
            fails++; $display("FAIL bp_latency: got %0d want 5", lat);
        end
        // Offer a sample while stalled; it must not be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0A80 || bus.in_ready !== 1'b0)
                bad++;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end
        consume();
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0A80) begin
            fails++;
            $display("FAIL bp_repeat: got v%b %h want v1 0a80", bus.out_valid, bus.out_data);
        end
        consume();
    endtask

    task automatic test_ignored_loads();
        bit ok;
        int lat;
        // Mismatched neuron and layer selects in IDLE.
        @(negedge clk);
        bus.cfg_layer  = 32'd1;
        bus.cfg_neuron = 32'd1;
        bus.w_valid    = 1'b1;
        bus.w_data     = 32'h0000_7FFF;
        bus.b_valid    = 1'b1;
        bus.b_data     = 32'h0000_7FFF;
        repeat (2) @(negedge clk);
        bus.cfg_layer  = 32'd2;
        bus.cfg_neuron = 32'd0;
        repeat (2) @(negedge clk);
        bus.w_valid = 1'b0;
        bus.b_valid = 1'b0;
        tests++;
        if (bus.w_load_done !== 1'b1) begin
            fails++; $display("FAIL ign_load_done: got %b want 1", bus.w_load_done);
        end
        // Gapped input with matched load strobes while accumulating.
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b1, 1'b1, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0A80) begin
            fails++;
            $display("FAIL ign_gapped: got v%b %h want v1 0a80", bus.out_valid, bus.out_data);
        end
        consume();
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0A80) begin
            fails++;
            $display("FAIL ign_ram_kept: got v%b %h want v1 0a80", bus.out_valid, bus.out_data);
        end
        consume();
    endtask

    task automatic test_reset_abort();
        bit ok;
        int lat;
        int seen;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0100;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: got v%b rdy%b busy%b want v0 rdy1 busy0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        tests++;
        if (bus.w_load_done !== 1'b0) begin
            fails++; $display("FAIL abort_load_done: got %b want 0", bus.w_load_done);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
        end
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, 1'b0, ok);
        wait_out(lat);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0A80) begin
            fails++;
            $display("FAIL abort_retained: got v%b %h want v1 0a80", bus.out_valid, bus.out_data);
        end
        consume();
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst            = 1'b1;
        bus.cfg_layer  = 32'd0;
        bus.cfg_neuron = 32'd0;
        bus.w_valid    = 1'b0;
        bus.w_data     = 32'd0;
        bus.b_valid    = 1'b0;
        bus.b_data     = 32'd0;
        bus.act_mode   = 2'd0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 16'sd0;
        bus.out_ready  = 1'b0;

        test_reset();
        test_basic();
        test_activation();
        test_saturation();
        test_backpressure();
        test_ignored_loads();
        test_reset_abort();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
